// File: rtl/systolic_pe_multimode.sv
// Multimode systolic MAC cell: OS / WS / IS / bypass dataflow, double-buffered stationary
// operand, optional saturating accumulator with sticky overflow, and an OS result drain.
module systolic_pe_multimode #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode_in,
  input  logic [IN_WIDTH-1:0]  left_in,
  input  logic                 left_valid_in,
  input  logic [ACC_WIDTH-1:0] top_in,
  input  logic                 top_valid_in,
  input  logic                 stat_load_in,
  input  logic                 stat_swap_in,
  input  logic                 acc_clear_in,
  input  logic                 drain_in,
  output logic [IN_WIDTH-1:0]  right_out,
  output logic                 right_valid_out,
  output logic [ACC_WIDTH-1:0] bottom_out,
  output logic                 bottom_valid_out,
  output logic                 overflow_out,
  output logic                 state_dbg_out
);

  localparam int PW  = 2 * IN_WIDTH;
  localparam int AW1 = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  localparam logic [1:0] MODE_OS  = 2'b00;
  localparam logic [1:0] MODE_WS  = 2'b01;
  localparam logic [1:0] MODE_IS  = 2'b10;

  // The emit step is taken on the edge that first sees drain_in in IDLE;
  // PASS then forwards upstream results while drain_in stays high.
  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [IN_WIDTH-1:0]    shadow_q, shadow_d;
  logic [IN_WIDTH-1:0]    active_q, active_d;
  logic [IN_WIDTH-1:0]    right_q, right_d;
  logic                   right_valid_q, right_valid_d;
  logic [ACC_WIDTH-1:0]   bottom_q, bottom_d;
  logic                   bottom_valid_q, bottom_valid_d;

  logic                   is_os, fire, emit, sum_ovf;
  logic [IN_WIDTH-1:0]    op2;
  logic signed [PW-1:0]   a_x, b_x, prod_w;
  logic [AW1-1:0]         prod_x, addend_x, sum;
  logic [ACC_WIDTH-1:0]   addend, sum_res;

  always_comb begin
    is_os    = (mode_in == MODE_OS);
    fire     = left_valid_in & top_valid_in;
    emit     = is_os & drain_in & (state_q == IDLE);
    op2      = is_os ? top_in[IN_WIDTH-1:0] : active_q;
    a_x      = {{IN_WIDTH{left_in[IN_WIDTH-1]}}, left_in};
    b_x      = {{IN_WIDTH{op2[IN_WIDTH-1]}}, op2};
    prod_w   = a_x * b_x;
    prod_x   = {{(AW1-PW){prod_w[PW-1]}}, prod_w};
    // Clear-then-add: a cleared accumulator contributes zero to this cycle's sum.
    addend   = is_os ? (acc_clear_in ? '0 : acc_q) : top_in;
    addend_x = {addend[ACC_WIDTH-1], addend};
    sum      = addend_x + prod_x;
    sum_ovf  = sum[AW1-1] ^ sum[AW1-2];
    if (SATURATE != 0 && sum_ovf) sum_res = sum[AW1-1] ? ACC_MIN : ACC_MAX;
    else                          sum_res = sum[ACC_WIDTH-1:0];
  end

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    ovf_d          = ovf_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    right_d        = right_q;
    right_valid_d  = left_valid_in;
    bottom_d       = bottom_q;
    bottom_valid_d = bottom_valid_q;

    if (left_valid_in) right_d = left_in;
    if (stat_swap_in)  active_d = shadow_q;
    if (stat_load_in)  shadow_d = top_in[IN_WIDTH-1:0];

    case (state_q)
      IDLE:    if (emit) state_d = PASS;
      PASS:    if (!is_os || !drain_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (emit) begin
      bottom_d       = acc_q;
      bottom_valid_d = 1'b1;
      acc_d          = fire ? prod_x[ACC_WIDTH-1:0] : '0;
      ovf_d          = 1'b0;
    end else begin
      if (acc_clear_in) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
      case (mode_in)
        MODE_OS: begin
          bottom_d       = top_in;
          bottom_valid_d = top_valid_in;
          if (fire) begin
            acc_d = sum_res;
            ovf_d = ovf_d | sum_ovf;
          end
        end
        MODE_WS, MODE_IS: begin
          bottom_valid_d = fire;
          if (fire) begin
            bottom_d = sum_res;
            ovf_d    = ovf_d | sum_ovf;
          end
        end
        default: begin
          bottom_d       = top_in;
          bottom_valid_d = top_valid_in;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      ovf_q          <= 1'b0;
      shadow_q       <= '0;
      active_q       <= '0;
      right_q        <= '0;
      right_valid_q  <= 1'b0;
      bottom_q       <= '0;
      bottom_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      ovf_q          <= ovf_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      right_q        <= right_d;
      right_valid_q  <= right_valid_d;
      bottom_q       <= bottom_d;
      bottom_valid_q <= bottom_valid_d;
    end
  end

  assign right_out        = right_q;
  assign right_valid_out  = right_valid_q;
  assign bottom_out       = bottom_q;
  assign bottom_valid_out = bottom_valid_q;
  assign overflow_out     = ovf_q;
  assign state_dbg_out    = (state_q == PASS);

endmodule

// File: tb/tb_systolic_pe_multimode.sv
// Bench for systolic_pe_multimode: saturating and wrapping instances share stimulus and
// are compared every cycle against an integer-arithmetic model, plus directed scenarios.
module tb_systolic_pe_multimode;
  localparam int IW = 8;
  localparam int AW = 16;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;
  localparam longint SPAN = 65536;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]    mode;
  logic [IW-1:0] left;
  logic          lv;
  logic [AW-1:0] top;
  logic          tv, ld, sw, clr, dr;

  logic [IW-1:0] right_s, right_w;
  logic          rv_s, rv_w;
  logic [AW-1:0] bot_s, bot_w;
  logic          bv_s, bv_w, ovf_s, ovf_w, st_s, st_w;

  int n_checks = 0;
  int n_pass   = 0;

  longint        m_acc [2];
  logic          m_ovf [2];
  logic [AW-1:0] m_bot [2];
  logic          m_bv  [2];
  logic [IW-1:0] m_shadow, m_active, m_right;
  logic          m_rv, m_in_drain;
  logic [AW-1:0] exp_q[$];

  systolic_pe_multimode #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .mode_in(mode), .left_in(left), .left_valid_in(lv),
    .top_in(top), .top_valid_in(tv), .stat_load_in(ld), .stat_swap_in(sw),
    .acc_clear_in(clr), .drain_in(dr), .right_out(right_s), .right_valid_out(rv_s),
    .bottom_out(bot_s), .bottom_valid_out(bv_s), .overflow_out(ovf_s), .state_dbg_out(st_s));

  systolic_pe_multimode #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .mode_in(mode), .left_in(left), .left_valid_in(lv),
    .top_in(top), .top_valid_in(tv), .stat_load_in(ld), .stat_swap_in(sw),
    .acc_clear_in(clr), .drain_in(dr), .right_out(right_w), .right_valid_out(rv_w),
    .bottom_out(bot_w), .bottom_valid_out(bv_w), .overflow_out(ovf_w), .state_dbg_out(st_w));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic out_of_range(input longint s);
    return (s > MAXV) || (s < MINV);
  endfunction

  function automatic longint fit(input longint s, input bit sat);
    if (s > MAXV) return sat ? MAXV : s - SPAN;
    if (s < MINV) return sat ? MINV : s + SPAN;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_ovf[k] = 1'b0; m_bot[k] = '0; m_bv[k] = 1'b0;
    end
    m_shadow = '0; m_active = '0; m_right = '0; m_rv = 1'b0; m_in_drain = 1'b0;
  endtask

  task automatic model_step();
    longint a, p_os, p_st, s, r;
    logic os, fire, emit;
    a    = longint'($signed(left));
    p_os = a * longint'($signed(top[IW-1:0]));
    p_st = a * longint'($signed(m_active));
    os   = (mode == 2'd0);
    fire = lv && tv;
    emit = os && dr && !m_in_drain;
    for (int k = 0; k < 2; k++) begin
      if (emit) begin
        m_bot[k] = m_acc[k][AW-1:0];
        m_bv[k]  = 1'b1;
        m_acc[k] = fire ? p_os : 0;
        m_ovf[k] = 1'b0;
      end else begin
        if (clr) begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
        if (mode == 2'd0) begin
          m_bot[k] = top; m_bv[k] = tv;
          if (fire) begin
            s = m_acc[k] + p_os;
            m_ovf[k] = m_ovf[k] | out_of_range(s);
            m_acc[k] = fit(s, k == 0);
          end
        end else if (mode == 2'd3) begin
          m_bot[k] = top; m_bv[k] = tv;
        end else begin
          m_bv[k] = fire;
          if (fire) begin
            s = longint'($signed(top)) + p_st;
            m_ovf[k] = m_ovf[k] | out_of_range(s);
            r = fit(s, k == 0);
            m_bot[k] = r[AW-1:0];
          end
        end
      end
    end
    if (lv) m_right = left;
    m_rv = lv;
    if (sw) m_active = m_shadow;
    if (ld) m_shadow = top[IW-1:0];
    m_in_drain = os && dr;
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".right"}, 32'(right_s), 32'(m_right));
    check({ph, ".rv"}, 32'(rv_s), 32'(m_rv));
    check({ph, ".right_w"}, 32'(right_w), 32'(m_right));
    check({ph, ".bot_s"}, 32'(bot_s), 32'(m_bot[0]));
    check({ph, ".bv_s"}, 32'(bv_s), 32'(m_bv[0]));
    check({ph, ".ovf_s"}, 32'(ovf_s), 32'(m_ovf[0]));
    check({ph, ".bot_w"}, 32'(bot_w), 32'(m_bot[1]));
    check({ph, ".bv_w"}, 32'(bv_w), 32'(m_bv[1]));
    check({ph, ".ovf_w"}, 32'(ovf_w), 32'(m_ovf[1]));
    check({ph, ".state"}, 32'(st_s), 32'(m_in_drain));
  endtask

  task automatic drive(input logic [1:0] m, input logic [IW-1:0] l, input logic l_v,
                       input logic [AW-1:0] t, input logic t_v, input logic i_ld,
                       input logic i_sw, input logic i_clr, input logic i_dr);
    mode = m; left = l; lv = l_v; top = t; tv = t_v;
    ld = i_ld; sw = i_sw; clr = i_clr; dr = i_dr;
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    #1;
    model_step();
    compare_all(ph);
  endtask

  initial begin
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // OS accumulate 1*5+2*6+3*7+4*8 = 70, then one-cycle drain
    for (int i = 1; i <= 4; i++) begin
      drive(2'd0, IW'(i), 1'b1, AW'(i + 4), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick("os_acc");
    end
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("os_drain");
    check("os_drain70", 32'(bot_s), 32'd70);
    check("os_drain_v", 32'(bv_s), 32'd1);
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("os_post");
    tick("os_post");
    check("os_idle", 32'(st_s), 32'd0);
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("os_zero");
    check("os_acc_zero", 32'(bot_s), 32'd0);

    // valid gating: left-only cycles never accumulate
    drive(2'd0, 8'd3, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick("gate");
    drive(2'd0, 8'd3, 1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("gate_fire");
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("gate_drain");
    check("gate12", 32'(bot_s), 32'd12);

    // saturation vs wrap: three fires of 127*127
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("sat_gap");
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 8'd127, 1'b1, 16'd127, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick("sat_fire");
    end
    check("sat_ovf_s", 32'(ovf_s), 32'd1);
    check("sat_ovf_w", 32'(ovf_w), 32'd1);
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("sat_drain");
    check("sat_clamp", 32'(bot_s), 32'h7fff);
    check("sat_wrap", 32'(bot_w), 32'hbd03);
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("sat_gap");
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 8'd127, 1'b1, 16'd127, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick("sat_fire2");
    end
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("sat_clear");
    check("sat_clr_ovf", 32'(ovf_s), 32'd0);
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("sat_clr_drain");
    check("sat_clr_acc", 32'(bot_s), 32'd0);

    // WS with double-buffered stationary operand
    drive(2'd1, '0, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("ws_load");
    drive(2'd1, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("ws_swap");
    drive(2'd1, 8'd2, 1'b1, 16'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("ws_mac");
    check("ws16", 32'(bot_s), 32'd16);
    drive(2'd1, '0, 1'b0, 16'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick("ws_ldsw");
    drive(2'd1, 8'd2, 1'b1, 16'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("ws_mac_old");
    check("ws_old_active", 32'(bot_s), 32'd16);
    drive(2'd1, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("ws_swap2");
    check("ws_hold", 32'(bot_s), 32'd16);
    drive(2'd1, 8'd2, 1'b1, 16'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("ws_mac_new");
    check("ws20", 32'(bot_s), 32'd20);

    // chained drain: 42 emitted, then upstream 99s forwarded
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("ch_clr");
    drive(2'd0, 8'd6, 1'b1, 16'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("ch_fire");
    exp_q.push_back(16'd42);
    exp_q.push_back(16'd99);
    exp_q.push_back(16'd99);
    drive(2'd0, '0, 1'b0, 16'd99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick("ch_drain");
      check("ch_seq", 32'(bot_s), 32'(exp_q.pop_front()));
      check("ch_valid", 32'(bv_s), 32'd1);
    end
    drive(2'd0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("ch_end");
    check("ch_idle", 32'(st_s), 32'd0);

    // asynchronous reset while in PASS
    drive(2'd0, 8'd2, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("rm_fire");
    drive(2'd0, '0, 1'b0, 16'd55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("rm_emit");
    tick("rm_pass");
    check("rm_in_pass", 32'(st_s), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rm_reset");
    check("rm_bot0", 32'(bot_s), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'd3, '0, 1'b0, 16'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("rm_byp");
    check("byp7", 32'(bot_s), 32'd7);

    // randomized traffic against the model
    begin
      logic [1:0] mr;
      mr = 2'd0;
      for (int i = 0; i < 800; i++) begin
        if (i % 16 == 0) mr = 2'($urandom_range(0, 3));
        drive(mr, IW'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
              AW'($urandom_range(0, 65535)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0));
        tick("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/systolic_pe_multimode.md
Name: systolic_pe_multimode

Overview:
- Parametrised next-generation systolic-array processing element: one MAC cell with separate operand and accumulator widths and signed arithmetic.
- Adds run-time dataflow mode (OS/WS/IS/bypass), per-lane valid bits, a double-buffered stationary register and an optional saturating accumulator with a sticky overflow flag.
- Adds a drain FSM that shifts output-stationary results down the column.
- Tiles in a ROWS x COLS grid: left->right for operand A, top->bottom for operand B or partial sums.

Parameters:
- IN_WIDTH, 16, signed operand width.
- ACC_WIDTH, 32, signed accumulator / partial-sum width; must be >= 2*IN_WIDTH.
- SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- mode_in  in  2  00 OS, 01 WS, 10 IS, 11 bypass.
- left_in  in  IN_WIDTH  streamed operand A.
- left_valid_in  in  1  qualifies left_in.
- top_in  in  ACC_WIDTH  OS/load: operand B in [IN_WIDTH-1:0]; WS/IS/drain: upstream partial sum or result.
- top_valid_in  in  1  qualifies top_in.
- stat_load_in  in  1  capture top_in[IN_WIDTH-1:0] into shadow register.
- stat_swap_in  in  1  copy shadow into active stationary register.
- acc_clear_in  in  1  clear accumulator and overflow flag.
- drain_in  in  1  OS result drain request, held high for whole drain.
- right_out  out  IN_WIDTH  registered operand A to east neighbour.
- right_valid_out  out  1  valid for right_out.
- bottom_out  out  ACC_WIDTH  registered value to south neighbour.
- bottom_valid_out  out  1  valid for bottom_out.
- overflow_out  out  1  sticky overflow flag.

Behaviour:
- Reset (async, immediate): all outputs 0; accumulator, shadow, active stationary 0; FSM = IDLE.
- All outputs registered; latency 1 cycle input->output.
- East lane, all modes:
  - right_valid_out <= left_valid_in.
  - right_out <= left_in when left_valid_in, else holds.
- Arithmetic:
  - product = signed(left) * signed(operand2), sign-extended to ACC_WIDTH+1.
  - sum computed at ACC_WIDTH+1 bits.
  - Overflow when sum is outside the signed ACC_WIDTH range.
  - SATURATE=1: clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1). SATURATE=0: truncate.
  - Either setting sets overflow_out, which stays set until acc_clear_in or rst.
- OS (00):
  - fire = left_valid_in & top_valid_in.
  - On fire: acc <= sat(acc + left_in*top_in[IN_WIDTH-1:0]); otherwise acc holds. A single valid never accumulates.
  - bottom_out <= top_in; bottom_valid_out <= top_valid_in (operand pass-down) while FSM = IDLE.
  - acc_clear_in with fire in the same cycle: acc <= product (clear then add).
- WS (01) / IS (10), identical PE datapath:
  - fire = left_valid_in & top_valid_in.
  - bottom_out <= sat(top_in + left_in*active_stat); bottom_valid_out <= fire. bottom_out holds when not fire.
  - Accumulator unused.
- Bypass (11):
  - bottom_out <= top_in; bottom_valid_out <= top_valid_in.
  - No arithmetic, no overflow update.
- Stationary registers:
  - stat_load_in: shadow <= top_in[IN_WIDTH-1:0], independent of top_valid_in.
  - stat_swap_in: active <= shadow.
  - Both in the same cycle: active gets the old shadow; shadow gets the new value.
  - Loading/swapping legal in any mode and does not stall streaming.
- Drain FSM (OS only):
  - IDLE -> EMIT on drain_in=1 in OS mode.
  - EMIT (1 cycle):
    - bottom_out <= acc value before this edge's update; bottom_valid_out <= 1.
    - acc <= product if fire, else 0; overflow cleared.
    - Next state PASS if drain_in is still 1, else IDLE.
  - PASS:
    - bottom_out <= top_in; bottom_valid_out <= top_valid_in (forwards upstream results).
    - Accumulation continues on fire.
    - drain_in=0 -> IDLE.
  - drain_in asserted in a non-OS mode is ignored.
  - mode_in change while not IDLE aborts to IDLE next cycle; mode_in changes are otherwise legal only in IDLE.
  - drain_in has priority over acc_clear_in in EMIT.
- Reset mid-drain or mid-accumulate: immediate return to reset state; no partial output is held.

Test Plan:
- Run with IN_WIDTH=8, ACC_WIDTH=16.
- OS accumulate: mode=00, 4 cycles left={1,2,3,4}, top={5,6,7,8} both valid, then drain_in 1 cycle -> bottom_out=70 with bottom_valid_out=1 exactly one cycle after drain_in, then acc=0, FSM IDLE.
- Valid gating: OS, left_valid=1 with top_valid=0 for 3 cycles, then one fire 3*4 -> drain result 12; right_valid_out tracks left_valid_in delayed 1 cycle.
- Saturation: OS, SATURATE=1, three fires of 127*127 -> acc=32767, overflow_out=1; acc_clear_in -> acc=0, overflow_out=0. With SATURATE=0, same stimulus -> acc wraps to -17149, overflow_out=1.
- WS with double buffering:
  - stat_load top=3, stat_swap; stream left=2, top=10 -> bottom_out=16.
  - In the same cycle, stat_load 5 + stat_swap -> active=3 that cycle.
  - Next swap -> left=2, top=10 gives 20.
- Chained drain: OS, acc=42; drain_in held 3 cycles with top_in=99 (valid) -> bottom_out sequence 42, 99, 99, valid each cycle, then IDLE.
- Async reset mid-drain: assert rst between clock edges during PASS -> all outputs 0 immediately; after release, mode=11 passes top_in=7 -> bottom_out=7 next cycle.
